// File: rtl/i2c_slave_regif.sv
// i2c_slave_regif: I2C/SCCB responder bridging bus transactions
// onto a byte-wide register file (pointer, auto-increment, Sr).
module i2c_slave_regif #(
  parameter int FILTER_LEN = 3
) (
  input  logic       iCLK,
  input  logic       rst,
  input  logic       I2C_SCLK,
  inout  wire        I2C_SDAT,
  input  logic [7:0] Slave_Addr,
  output logic [7:0] REG_ADDR,
  output logic [7:0] REG_WDATA,
  output logic       REG_WE,
  input  logic [7:0] REG_RDATA,
  output logic       BUSY
);

  localparam int CW = $clog2(FILTER_LEN + 1);

  localparam logic [3:0] S_IDLE      = 4'd0;
  localparam logic [3:0] S_ADDR      = 4'd1;
  localparam logic [3:0] S_ADDR_ACK  = 4'd2;
  localparam logic [3:0] S_PTR       = 4'd3;
  localparam logic [3:0] S_PTR_ACK   = 4'd4;
  localparam logic [3:0] S_WDATA     = 4'd5;
  localparam logic [3:0] S_WDATA_ACK = 4'd6;
  localparam logic [3:0] S_RDATA     = 4'd7;
  localparam logic [3:0] S_RDATA_ACK = 4'd8;
  localparam logic [3:0] S_WAIT      = 4'd9;

  // index 1 = SCL, index 0 = SDA
  logic [1:0]    sy1, sy2, filt, prev;
  logic [CW-1:0] fcnt [2];

  logic [3:0] state;
  logic [3:0] bcnt;
  logic [7:0] sr;
  logic       sda_oe;
  logic       inc_pend;

  logic       scl_rise, scl_fall, scl_hi;
  logic       sda_rise, sda_fall;
  logic       start_c, stop_c;
  logic [7:0] rx_byte;
  logic       unused_addr_lsb;

  assign I2C_SDAT = sda_oe ? 1'b0 : 1'bz;

  assign scl_rise = filt[1] & ~prev[1];
  assign scl_fall = ~filt[1] & prev[1];
  assign scl_hi   = filt[1] & prev[1];
  assign sda_rise = filt[0] & ~prev[0];
  assign sda_fall = ~filt[0] & prev[0];
  // our own pull-down must never look like a bus condition
  assign start_c  = scl_hi & sda_fall & ~sda_oe;
  assign stop_c   = scl_hi & sda_rise & ~sda_oe;
  assign rx_byte  = {sr[6:0], filt[0]};
  assign unused_addr_lsb = Slave_Addr[0];

  // synchronise both lines, then require a stable run before accepting a level
  always_ff @(posedge iCLK) begin
    if (rst) begin
      sy1  <= 2'b11;
      sy2  <= 2'b11;
      filt <= 2'b11;
      prev <= 2'b11;
      for (int i = 0; i < 2; i++) fcnt[i] <= '0;
    end else begin
      sy1  <= {I2C_SCLK, I2C_SDAT};
      sy2  <= sy1;
      prev <= filt;
      for (int i = 0; i < 2; i++) begin
        if (sy2[i] == filt[i]) begin
          fcnt[i] <= '0;
        end else if (fcnt[i] == CW'(FILTER_LEN - 1)) begin
          filt[i] <= sy2[i];
          fcnt[i] <= '0;
        end else begin
          fcnt[i] <= fcnt[i] + CW'(1);
        end
      end
    end
  end

  // protocol FSM: shift in on SCL rise, change SDA drive on SCL fall
  always_ff @(posedge iCLK) begin
    if (rst) begin
      state     <= S_IDLE;
      bcnt      <= '0;
      sr        <= '0;
      sda_oe    <= 1'b0;
      inc_pend  <= 1'b0;
      REG_ADDR  <= '0;
      REG_WDATA <= '0;
      REG_WE    <= 1'b0;
      BUSY      <= 1'b0;
    end else begin
      REG_WE <= 1'b0;
      if (inc_pend) begin
        REG_ADDR <= REG_ADDR + 8'd1;
        inc_pend <= 1'b0;
      end
      if (start_c) begin
        state  <= S_ADDR;
        bcnt   <= '0;
        sda_oe <= 1'b0;
        BUSY   <= 1'b0;
      end else if (stop_c) begin
        state  <= S_IDLE;
        sda_oe <= 1'b0;
        BUSY   <= 1'b0;
      end else begin
        unique case (state)
          S_ADDR, S_PTR, S_WDATA: begin
            if (scl_rise && bcnt != 4'd8) begin
              sr   <= rx_byte;
              bcnt <= bcnt + 4'd1;
              if (bcnt == 4'd7) begin
                if (state == S_PTR) begin
                  REG_ADDR <= rx_byte;
                end else if (state == S_WDATA) begin
                  REG_WDATA <= rx_byte;
                  REG_WE    <= 1'b1;
                  inc_pend  <= 1'b1;
                end
              end
            end else if (scl_fall && bcnt == 4'd8) begin
              bcnt <= '0;
              if (state == S_ADDR) begin
                if (sr[7:1] == Slave_Addr[7:1]) begin
                  sda_oe <= 1'b1;
                  BUSY   <= 1'b1;
                  state  <= S_ADDR_ACK;
                end else begin
                  state <= S_WAIT;
                end
              end else begin
                sda_oe <= 1'b1;
                state  <= (state == S_PTR) ? S_PTR_ACK : S_WDATA_ACK;
              end
            end
          end
          S_ADDR_ACK, S_PTR_ACK, S_WDATA_ACK: begin
            if (scl_fall) begin
              // sr still holds the address byte, so sr[0] is R/W
              if (state == S_ADDR_ACK && sr[0]) begin
                sr     <= REG_RDATA;
                sda_oe <= ~REG_RDATA[7];
                bcnt   <= 4'd1;
                state  <= S_RDATA;
              end else begin
                sda_oe <= 1'b0;
                state  <= (state == S_ADDR_ACK) ? S_PTR : S_WDATA;
              end
            end
          end
          S_RDATA: begin
            if (scl_fall) begin
              if (bcnt == 4'd0) begin
                sr     <= REG_RDATA;
                sda_oe <= ~REG_RDATA[7];
                bcnt   <= 4'd1;
              end else if (bcnt == 4'd8) begin
                sda_oe <= 1'b0;
                bcnt   <= '0;
                state  <= S_RDATA_ACK;
              end else begin
                sda_oe <= ~sr[6];
                sr     <= {sr[6:0], 1'b0};
                bcnt   <= bcnt + 4'd1;
              end
            end
          end
          S_RDATA_ACK: begin
            if (scl_rise) begin
              if (!filt[0]) begin
                REG_ADDR <= REG_ADDR + 8'd1;
                bcnt     <= '0;
                state    <= S_RDATA;
              end else begin
                BUSY  <= 1'b0;
                state <= S_WAIT;
              end
            end
          end
          default: begin
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_i2c_slave_regif.sv
// tb_i2c_slave_regif: bit-banged I2C master with write scoreboard
// and table-driven single-write vectors plus corner-case sequences.
module tb_i2c_slave_regif;

  localparam int Q = 10;

  logic       iCLK = 1'b0;
  logic       rst = 1'b1;
  logic       scl = 1'b1;
  logic       m_sda = 1'b1;
  wire        sda;
  logic [7:0] Slave_Addr = 8'h42;
  logic [7:0] REG_ADDR, REG_WDATA, REG_RDATA;
  logic       REG_WE, BUSY;

  logic [7:0]  mem [256];
  logic [15:0] exp_we [$];
  logic [15:0] e_we;
  int          checks = 0;
  int          failures = 0;
  int          we_count = 0;
  bit          busy_seen = 0;
  bit          dut_drove = 0;

  typedef struct {
    logic [7:0] ptr;
    logic [7:0] data;
    logic [7:0] exp_addr;
  } wr_vec_t;
  wr_vec_t vt [4];

  always #5 iCLK = ~iCLK;

  assign sda = m_sda ? 1'bz : 1'b0;
  pullup (sda);
  assign REG_RDATA = mem[REG_ADDR];

  i2c_slave_regif #(.FILTER_LEN(3)) dut (
    .iCLK      (iCLK),
    .rst       (rst),
    .I2C_SCLK  (scl),
    .I2C_SDAT  (sda),
    .Slave_Addr(Slave_Addr),
    .REG_ADDR  (REG_ADDR),
    .REG_WDATA (REG_WDATA),
    .REG_WE    (REG_WE),
    .REG_RDATA (REG_RDATA),
    .BUSY      (BUSY)
  );

  task automatic chk(input string name, input logic [15:0] act,
                     input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic wq(input int n);
    repeat (n) @(negedge iCLK);
  endtask

  task automatic b_start();
    m_sda = 1'b1; scl = 1'b1; wq(Q);
    m_sda = 1'b0; wq(Q);
    scl = 1'b0; wq(Q);
  endtask

  task automatic b_rstart();
    m_sda = 1'b1; wq(Q);
    scl = 1'b1; wq(Q);
    m_sda = 1'b0; wq(Q);
    scl = 1'b0; wq(Q);
  endtask

  task automatic b_stop();
    m_sda = 1'b0; wq(Q);
    scl = 1'b1; wq(Q);
    m_sda = 1'b1; wq(Q);
  endtask

  task automatic b_bit(input logic b, output logic r);
    m_sda = b; wq(Q);
    scl = 1'b1; wq(Q);
    r = sda; wq(Q);
    scl = 1'b0; wq(Q);
  endtask

  task automatic b_wbyte(input logic [7:0] d, output logic ack);
    logic r;
    for (int i = 7; i >= 0; i--) b_bit(d[i], r);
    b_bit(1'b1, ack);
  endtask

  task automatic b_rbyte(input logic mack, output logic [7:0] d);
    logic r;
    for (int i = 7; i >= 0; i--) begin
      b_bit(1'b1, r);
      d[i] = r;
    end
    b_bit(mack, r);
  endtask

  // write-strobe scoreboard and bus activity monitor
  always @(negedge iCLK) begin
    if (!rst) begin
      if (BUSY) busy_seen = 1;
      if (sda === 1'b0 && m_sda) dut_drove = 1;
      if (REG_WE) begin
        we_count++;
        if (exp_we.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL we_unexpected: got addr %h data %h expected none",
                   REG_ADDR, REG_WDATA);
        end else begin
          e_we = exp_we.pop_front();
          chk("we_addr_data", {REG_ADDR, REG_WDATA}, e_we);
        end
      end
    end
  end

  initial begin
    #2ms;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic       a;
    logic [7:0] d;
    int         w0;

    for (int i = 0; i < 256; i++) mem[i] = 8'h00;
    mem[8'h0A] = 8'hA5;
    mem[8'h0B] = 8'h3C;

    vt[0] = '{ptr: 8'h12, data: 8'h80, exp_addr: 8'h13};
    vt[1] = '{ptr: 8'h3F, data: 8'hC3, exp_addr: 8'h40};
    vt[2] = '{ptr: 8'h00, data: 8'hFF, exp_addr: 8'h01};
    vt[3] = '{ptr: 8'hFF, data: 8'h5A, exp_addr: 8'h00};

    wq(5);
    rst = 1'b0;
    wq(5);
    chk("rst_addr", REG_ADDR, 0);
    chk("rst_wdata", REG_WDATA, 0);
    chk("rst_we", REG_WE, 0);
    chk("rst_busy", BUSY, 0);
    chk("rst_sda", sda, 1);

    // single writes from the vector table
    for (int i = 0; i < 4; i++) begin
      b_start();
      b_wbyte(8'h42, a);
      chk("wr_addr_ack", a, 0);
      chk("wr_busy", BUSY, 1);
      b_wbyte(vt[i].ptr, a);
      chk("wr_ptr_ack", a, 0);
      exp_we.push_back({vt[i].ptr, vt[i].data});
      b_wbyte(vt[i].data, a);
      chk("wr_data_ack", a, 0);
      b_stop();
      wq(4);
      chk("wr_final_addr", REG_ADDR, vt[i].exp_addr);
      chk("wr_wdata", REG_WDATA, vt[i].data);
      chk("wr_busy_end", BUSY, 0);
    end

    // burst write across the 0xFF -> 0x00 wrap
    b_start();
    b_wbyte(8'h42, a);
    chk("burst_addr_ack", a, 0);
    b_wbyte(8'hFE, a);
    chk("burst_ptr_ack", a, 0);
    exp_we.push_back(16'hFE11);
    b_wbyte(8'h11, a);
    chk("burst_d0_ack", a, 0);
    exp_we.push_back(16'hFF22);
    b_wbyte(8'h22, a);
    chk("burst_d1_ack", a, 0);
    exp_we.push_back(16'h0033);
    b_wbyte(8'h33, a);
    chk("burst_d2_ack", a, 0);
    b_stop();
    wq(4);
    chk("burst_final_addr", REG_ADDR, 8'h01);

    // pointer write, repeated START, two-byte read
    w0 = we_count;
    b_start();
    b_wbyte(8'h42, a);
    chk("rd_waddr_ack", a, 0);
    b_wbyte(8'h0A, a);
    chk("rd_ptr_ack", a, 0);
    b_rstart();
    b_wbyte(8'h43, a);
    chk("rd_raddr_ack", a, 0);
    chk("rd_busy", BUSY, 1);
    b_rbyte(1'b0, d);
    chk("rd_byte0", d, 8'hA5);
    b_rbyte(1'b1, d);
    chk("rd_byte1", d, 8'h3C);
    wq(2);
    chk("rd_sda_released", sda, 1);
    chk("rd_busy_after_nack", BUSY, 0);
    chk("rd_final_addr", REG_ADDR, 8'h0B);
    b_stop();
    wq(4);
    chk("rd_no_we", we_count - w0, 0);

    // foreign address: never acknowledged
    w0 = we_count;
    busy_seen = 0;
    dut_drove = 0;
    b_start();
    b_wbyte(8'h60, a);
    chk("mm_addr_nack", a, 1);
    b_wbyte(8'h01, a);
    chk("mm_b1_nack", a, 1);
    b_wbyte(8'h02, a);
    chk("mm_b2_nack", a, 1);
    b_stop();
    wq(4);
    chk("mm_busy_seen", busy_seen, 0);
    chk("mm_sda_driven", dut_drove, 0);
    chk("mm_no_we", we_count - w0, 0);

    // STOP after four data bits
    w0 = we_count;
    b_start();
    b_wbyte(8'h42, a);
    chk("ab_addr_ack", a, 0);
    b_wbyte(8'h20, a);
    chk("ab_ptr_ack", a, 0);
    b_bit(1'b1, a);
    b_bit(1'b0, a);
    b_bit(1'b1, a);
    b_bit(1'b0, a);
    b_stop();
    wq(4);
    chk("ab_no_we", we_count - w0, 0);
    chk("ab_addr", REG_ADDR, 8'h20);
    chk("ab_busy", BUSY, 0);

    // reset in the middle of a read byte
    b_start();
    b_wbyte(8'h43, a);
    chk("ab_rd_ack", a, 0);
    b_bit(1'b1, a);
    b_bit(1'b1, a);
    chk("ab_rd_driving", sda, 0);
    rst = 1'b1;
    wq(1);
    chk("ab_rst_sda", sda, 1);
    chk("ab_rst_busy", BUSY, 0);
    chk("ab_rst_addr", REG_ADDR, 0);
    wq(2);
    rst = 1'b0;
    m_sda = 1'b1;
    scl = 1'b1;
    wq(2 * Q);

    // 2-cycle SDA glitch with SCL high: no START
    m_sda = 1'b0;
    wq(2);
    m_sda = 1'b1;
    wq(Q);
    scl = 1'b0;
    wq(Q);
    b_wbyte(8'h42, a);
    chk("glitch2_nack", a, 1);
    chk("glitch2_busy", BUSY, 0);
    b_stop();
    wq(Q);

    // 3-cycle SDA low with SCL high: START
    m_sda = 1'b0;
    wq(3);
    scl = 1'b0;
    wq(Q);
    b_wbyte(8'h42, a);
    chk("glitch3_ack", a, 0);
    chk("glitch3_busy", BUSY, 1);
    b_stop();
    wq(4);
    chk("glitch3_busy_end", BUSY, 0);

    chk("we_queue_empty", exp_we.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
